// File: rtl/fake_qspi0_icb_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fake_qspi0_icb_rd_pkg
//  Description : Shared types and constants for the fake QSPI0 ICB read
//                front-end (state encoding, ICB widths, default window base).
//  Revision    : 1.0 - initial release
// ============================================================================
package fake_qspi0_icb_rd_pkg;

    // ICB bus widths
    localparam int unsigned C_ICB_AW = 32;
    localparam int unsigned C_ICB_DW = 32;
    localparam int unsigned C_ICB_MW = 4;

    // Default byte base of the flash XIP window
    localparam logic [C_ICB_AW-1:0] C_DEFAULT_BASE_ADDR = 32'h2000_0000;

    // Front-end controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage : fake_qspi0_icb_rd_pkg
`default_nettype wire

// File: rtl/fake_qspi0_icb_rd.sv
`default_nettype none
// ============================================================================
//  Module      : fake_qspi0_icb_rd
//  Description : ICB slave front-end for the combinational fake QSPI0 flash
//                model. Accepts one read at a time, drives the registered
//                ROM word address, waits WAIT_CYC cycles to emulate flash
//                latency, then returns the registered word. Writes and
//                out-of-window reads complete immediately with an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module fake_qspi0_icb_rd
    import fake_qspi0_icb_rd_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = C_DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 52,
    parameter int unsigned WAIT_CYC    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_icb_cmd_valid,
    output logic                i_icb_cmd_ready,
    input  logic [C_ICB_AW-1:0] i_icb_cmd_addr,
    input  logic                i_icb_cmd_read,
    input  logic [C_ICB_DW-1:0] i_icb_cmd_wdata,
    input  logic [C_ICB_MW-1:0] i_icb_cmd_wmask,
    output logic                i_icb_rsp_valid,
    input  logic                i_icb_rsp_ready,
    output logic [C_ICB_DW-1:0] i_icb_rsp_rdata,
    output logic                i_icb_rsp_err,
    output logic [29:0]         model_addr,
    input  logic [C_ICB_DW-1:0] model_dout
);

    // Counter reload: WAIT_CYC-1 so that WAIT lasts exactly WAIT_CYC cycles
    localparam logic [7:0] C_WAIT_LOAD = 8'((WAIT_CYC == 0) ? 0 : (WAIT_CYC - 1));
    localparam logic       C_NO_WAIT   = (WAIT_CYC == 0);

    state_t                r_state;
    state_t                w_state_nxt;
    logic   [7:0]          r_wait_cnt;
    logic   [C_ICB_DW-1:0] r_rdata;
    logic                  r_err;
    logic   [29:0]         r_model_addr;

    logic                  w_accept;
    logic   [C_ICB_AW-1:0] w_offset;
    logic                  w_below_base;
    logic                  w_beyond_depth;
    logic                  w_cmd_err;
    logic                  w_unused;

    // Write payload and the byte lane bits are irrelevant to a word ROM
    assign w_unused = ^{i_icb_cmd_wdata, i_icb_cmd_wmask, w_offset[1:0]};

    assign i_icb_cmd_ready = (r_state == ST_IDLE);
    assign i_icb_rsp_valid = (r_state == ST_RESP);
    assign i_icb_rsp_rdata = r_rdata;
    assign i_icb_rsp_err   = r_err;
    assign model_addr      = r_model_addr;

    assign w_accept       = i_icb_cmd_valid & i_icb_cmd_ready;
    assign w_offset       = i_icb_cmd_addr - BASE_ADDR;
    // Subtraction wraps for addresses under the base, so that case is
    // caught by its own compare rather than by the depth check.
    assign w_below_base   = (i_icb_cmd_addr < BASE_ADDR);
    assign w_beyond_depth = (w_offset[31:2] >= 30'(DEPTH_WORDS));
    assign w_cmd_err      = ~i_icb_cmd_read | w_below_base | w_beyond_depth;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_err) begin
                        w_state_nxt = ST_RESP;
                    end else if (C_NO_WAIT) begin
                        w_state_nxt = ST_CAPT;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 8'd0) begin
                    w_state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (i_icb_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: ROM address latch, latency counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_model_addr <= 30'd0;
            r_wait_cnt   <= 8'd0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Address held until the next accept so the ROM
                        // output is settled by the time CAPT samples it.
                        r_model_addr <= w_offset[31:2];
                        if (w_cmd_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_wait_cnt <= C_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt != 8'd0) begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end
                end
                ST_CAPT: begin
                    r_rdata <= model_dout;
                    r_err   <= 1'b0;
                end
                default: begin
                    // RESP: rdata/err held until the response handshake
                end
            endcase
        end
    end

endmodule : fake_qspi0_icb_rd
`default_nettype wire

// File: tb/tb_fake_qspi0_icb_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fake_qspi0_icb_rd
//  Description : Directed self-checking bench for fake_qspi0_icb_rd. DUT A
//                uses WAIT_CYC=4, DUT B uses WAIT_CYC=0; each has its own
//                small combinational ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fake_qspi0_icb_rd;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_err;

    // DUT A signals (WAIT_CYC = 4)
    logic        a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [31:0] a_cmd_addr, a_cmd_wdata;
    logic [3:0]  a_cmd_wmask;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic [29:0] a_model_addr;
    logic [31:0] a_model_dout;

    // DUT B signals (WAIT_CYC = 0)
    logic        b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [31:0] b_cmd_addr, b_cmd_wdata;
    logic [3:0]  b_cmd_wmask;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [29:0] b_model_addr;
    logic [31:0] b_model_dout;

    // Fake flash contents: known words from the test plan, filler elsewhere
    function automatic logic [31:0] rom(input logic [29:0] wa);
        case (wa)
            30'd0:   rom = 32'h7000_1197;
            30'd1:   rom = 32'h0A81_8193;
            30'd48:  rom = 32'h6000_4317;
            30'd50:  rom = 32'h0000_A001;
            30'd51:  rom = 32'h0000_0000;
            default: rom = 32'hC0DE_0000 | 32'(wa);
        endcase
    endfunction

    assign a_model_dout = rom(a_model_addr);
    assign b_model_dout = rom(b_model_addr);

    fake_qspi0_icb_rd #(
        .BASE_ADDR  (32'h2000_0000),
        .DEPTH_WORDS(52),
        .WAIT_CYC   (4)
    ) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (a_cmd_valid),
        .i_icb_cmd_ready (a_cmd_ready),
        .i_icb_cmd_addr  (a_cmd_addr),
        .i_icb_cmd_read  (a_cmd_read),
        .i_icb_cmd_wdata (a_cmd_wdata),
        .i_icb_cmd_wmask (a_cmd_wmask),
        .i_icb_rsp_valid (a_rsp_valid),
        .i_icb_rsp_ready (a_rsp_ready),
        .i_icb_rsp_rdata (a_rsp_rdata),
        .i_icb_rsp_err   (a_rsp_err),
        .model_addr      (a_model_addr),
        .model_dout      (a_model_dout)
    );

    fake_qspi0_icb_rd #(
        .BASE_ADDR  (32'h2000_0000),
        .DEPTH_WORDS(52),
        .WAIT_CYC   (0)
    ) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (b_cmd_valid),
        .i_icb_cmd_ready (b_cmd_ready),
        .i_icb_cmd_addr  (b_cmd_addr),
        .i_icb_cmd_read  (b_cmd_read),
        .i_icb_cmd_wdata (b_cmd_wdata),
        .i_icb_cmd_wmask (b_cmd_wmask),
        .i_icb_rsp_valid (b_rsp_valid),
        .i_icb_rsp_ready (b_rsp_ready),
        .i_icb_rsp_rdata (b_rsp_rdata),
        .i_icb_rsp_err   (b_rsp_err),
        .model_addr      (b_model_addr),
        .model_dout      (b_model_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One DUT A transaction with rsp_ready high; latency counted from accept
    task automatic a_xfer(input string tag, input logic [31:0] addr, input logic rd,
                          input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_err, input logic [29:0] exp_waddr);
        int n;
        @(negedge clk);
        check({tag, ".cmd_ready"}, 32'(a_cmd_ready), 32'd1);
        a_cmd_valid = 1'b1;
        a_cmd_addr  = addr;
        a_cmd_read  = rd;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!a_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".rdata"}, a_rsp_rdata, exp_data);
        check({tag, ".err"}, 32'(a_rsp_err), 32'(exp_err));
        check({tag, ".model_addr"}, 32'(a_model_addr), 32'(exp_waddr));
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, ".rsp_drop"}, 32'(a_rsp_valid), 32'd0);
    endtask

    // One DUT B transaction with rsp_ready high
    task automatic b_xfer(input string tag, input logic [31:0] addr,
                          input int exp_lat, input logic [31:0] exp_data);
        int n;
        @(negedge clk);
        b_cmd_valid = 1'b1;
        b_cmd_addr  = addr;
        b_cmd_read  = 1'b1;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!b_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".rdata"}, b_rsp_rdata, exp_data);
        check({tag, ".err"}, 32'(b_rsp_err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        logic ok;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_addr = '0; a_cmd_read = 1'b1;
        a_cmd_wdata = 32'hFFFF_FFFF; a_cmd_wmask = 4'hF; a_rsp_ready = 1'b1;
        b_cmd_valid = 1'b0; b_cmd_addr = '0; b_cmd_read = 1'b1;
        b_cmd_wdata = 32'h5555_AAAA; b_cmd_wmask = 4'h3; b_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.cmd_ready",  32'(a_cmd_ready), 32'd1);
        check("rst.rsp_valid",  32'(a_rsp_valid), 32'd0);
        check("rst.rdata",      a_rsp_rdata,      32'd0);
        check("rst.err",        32'(a_rsp_err),   32'd0);
        check("rst.model_addr", 32'(a_model_addr), 32'd0);
        rst_n = 1'b1;

        // Basic read, WAIT_CYC=4
        a_xfer("rd0", 32'h2000_0000, 1'b1, 6, 32'h7000_1197, 1'b0, 30'd0);

        // Back-to-back with cmd_valid held across the first transaction
        @(negedge clk);
        a_cmd_valid = 1'b1; a_cmd_addr = 32'h2000_0004; a_cmd_read = 1'b1;
        @(posedge clk);
        #1;
        a_cmd_addr = 32'h2000_00C8;
        ok = 1'b1;
        n = 1;
        @(negedge clk);
        while (!a_rsp_valid && n < 40) begin
            if (a_cmd_ready) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("b2b1.latency", 32'(n), 32'd6);
        check("b2b1.rdata", a_rsp_rdata, 32'h0A81_8193);
        check("b2b1.busy", 32'(ok & ~a_cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b2.cmd_ready", 32'(a_cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!a_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b2.latency", 32'(n), 32'd6);
        check("b2b2.rdata", a_rsp_rdata, 32'h0000_A001);
        check("b2b2.model_addr", 32'(a_model_addr), 32'd50);
        @(posedge clk);
        #1;

        // Backpressure: rsp_ready low for 10 cycles
        @(negedge clk);
        a_rsp_ready = 1'b0;
        a_cmd_valid = 1'b1; a_cmd_addr = 32'h2000_00C0; a_cmd_read = 1'b1;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!a_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp.latency", 32'(n), 32'd6);
        check("bp.rdata", a_rsp_rdata, 32'h6000_4317);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!a_rsp_valid || a_rsp_rdata !== 32'h6000_4317 || a_cmd_ready || a_rsp_err)
                ok = 1'b0;
        end
        check("bp.hold", 32'(ok), 32'd1);
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp.release_valid", 32'(a_rsp_valid), 32'd0);
        check("bp.release_ready", 32'(a_cmd_ready), 32'd1);

        // Error responses: write, past last word, below base
        a_xfer("err_wr",  32'h2000_0000, 1'b0, 1, 32'd0, 1'b1, 30'd0);
        a_xfer("err_oor", 32'h2000_00D0, 1'b1, 1, 32'd0, 1'b1, 30'd52);
        a_xfer("rd_last", 32'h2000_00CC, 1'b1, 6, 32'h0000_0000, 1'b0, 30'd51);
        a_xfer("rd1",     32'h2000_0004, 1'b1, 6, 32'h0A81_8193, 1'b0, 30'd1);
        a_xfer("err_low", 32'h1FFF_FFFC, 1'b1, 1, 32'd0, 1'b1, 30'h3FFF_FFFF);

        // WAIT_CYC=0 instance
        b_xfer("b_rd0",  32'h2000_0000, 2, 32'h7000_1197);
        b_xfer("b_last", 32'h2000_00CC, 2, 32'h0000_0000);

        // Asynchronous reset while in WAIT drops the transaction
        @(negedge clk);
        a_cmd_valid = 1'b1; a_cmd_addr = 32'h2000_0004; a_cmd_read = 1'b1;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        @(negedge clk);
        check("rstw.cmd_ready_busy", 32'(a_cmd_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw.rsp_valid",  32'(a_rsp_valid), 32'd0);
        check("rstw.cmd_ready",  32'(a_cmd_ready), 32'd1);
        check("rstw.model_addr", 32'(a_model_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (a_rsp_valid) ok = 1'b0;
        end
        check("rstw.no_rsp", 32'(ok), 32'd1);
        a_xfer("rstw.rd0", 32'h2000_0000, 1'b1, 6, 32'h7000_1197, 1'b0, 30'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fake_qspi0_icb_rd
`default_nettype wire
